// File: rtl/ed_capture.sv
// Input-capture block: synchronises OUT_BITS channels, detects rising edges and
// queues {channel mask, count, outer_count} timestamps for a valid/ready consumer.
module ed_capture #(
  parameter int IN_BITS    = 32,
  parameter int OUT_BITS   = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_LOG2  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_BITS-1:0]    count,
  input  logic [IN_BITS-1:0]    outer_count,
  input  logic [OUT_BITS-1:0]   ch_in,
  input  logic [OUT_BITS-1:0]   ch_mask,
  input  logic                  enable,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_BITS-1:0]   out_chans,
  output logic [IN_BITS-1:0]    out_count,
  output logic [IN_BITS-1:0]    out_outer,
  output logic [FIFO_LOG2:0]    fifo_level,
  output logic                  overflow,
  output logic [15:0]           dropped,
  input  logic                  clear_overflow
);

  typedef struct packed {
    logic [OUT_BITS-1:0] chans;
    logic [IN_BITS-1:0]  cnt;
    logic [IN_BITS-1:0]  outer;
  } entry_t;

  localparam logic [FIFO_LOG2:0] LVL_FULL = (FIFO_LOG2+1)'(FIFO_DEPTH);

  logic [OUT_BITS-1:0]  r_s1, r_s2, r_s3;
  logic [OUT_BITS-1:0]  w_edge, w_cap;
  entry_t               r_mem [FIFO_DEPTH];
  entry_t               r_head, w_head_nxt, w_wdata;
  logic [FIFO_LOG2-1:0] r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [FIFO_LOG2:0]   r_level, w_level_nxt, w_level_after_pop;
  logic                 r_ovf;
  logic [15:0]          r_drp;
  logic                 w_full, w_pop, w_any, w_wr, w_drop;

  // Synchroniser runs unconditionally so a pre-existing high level never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= ch_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge  = r_s2 & ~r_s3;
  assign w_cap   = w_edge & ch_mask & {OUT_BITS{enable}};
  assign w_wdata = '{chans: w_cap, cnt: count, outer: outer_count};

  assign out_valid = (r_level != '0);
  assign w_full    = (r_level == LVL_FULL);
  assign w_pop     = out_valid && out_ready;
  assign w_any     = |w_cap;
  assign w_wr      = w_any && (!w_full || w_pop);
  assign w_drop    = w_any && w_full && !w_pop;

  assign w_rd_nxt          = w_pop ? r_rd_ptr + FIFO_LOG2'(1) : r_rd_ptr;
  assign w_level_after_pop = r_level - {{FIFO_LOG2{1'b0}}, w_pop};
  assign w_level_nxt       = w_level_after_pop + {{FIFO_LOG2{1'b0}}, w_wr};

  // Head register tracks the next head; when the queue drains empty it holds the last value.
  always_comb begin
    w_head_nxt = r_head;
    if (w_level_nxt != '0) begin
      if (w_level_after_pop == '0) w_head_nxt = w_wdata;
      else                         w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_head   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + FIFO_LOG2'(1);
      r_rd_ptr <= w_rd_nxt;
      r_level  <= w_level_nxt;
      r_head   <= w_head_nxt;
    end
  end

  // Clear takes priority, but a drop in the same cycle still registers as the first one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_drp <= '0;
    end else if (clear_overflow) begin
      r_ovf <= w_drop;
      r_drp <= {15'd0, w_drop};
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drp != 16'hFFFF) r_drp <= r_drp + 16'd1;
    end
  end

  assign out_chans  = r_head.chans;
  assign out_count  = r_head.cnt;
  assign out_outer  = r_head.outer;
  assign fifo_level = r_level;
  assign overflow   = r_ovf;
  assign dropped    = r_drp;

endmodule

// File: tb/tb_ed_capture.sv
// Randomised + directed bench for ed_capture: a queue-based reference model
// predicts timestamp entries; a negedge monitor compares the DUT against it.
module tb_ed_capture;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] count = '0, outer_count = '0;
  logic [7:0]  ch_in = '0, ch_mask = '0;
  logic        enable = 1'b0, out_ready = 1'b0, clear_overflow = 1'b0;
  logic        out_valid, overflow;
  logic [7:0]  out_chans;
  logic [31:0] out_count, out_outer;
  logic [4:0]  fifo_level;
  logic [15:0] dropped;

  ed_capture #(.IN_BITS(32), .OUT_BITS(8), .FIFO_DEPTH(DEPTH), .FIFO_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .count(count), .outer_count(outer_count),
    .ch_in(ch_in), .ch_mask(ch_mask), .enable(enable),
    .out_valid(out_valid), .out_ready(out_ready), .out_chans(out_chans),
    .out_count(out_count), .out_outer(out_outer), .fifo_level(fifo_level),
    .overflow(overflow), .dropped(dropped), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  c;
    logic [31:0] n;
    logic [31:0] o;
  } ent_t;

  ent_t       exp_q[$];
  logic [7:0] hist[$];
  int         m_ovf = 0, m_drp = 0;
  int         n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an input edge is a channel that was low two samples before
  // and high one sample later; the timestamp is whatever count is on the bus now.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      hist.delete();
      for (int i = 0; i < 3; i++) hist.push_back(8'h00);
      m_ovf = 0;
      m_drp = 0;
    end else begin
      logic [7:0] cap;
      bit         pop, drop;
      ent_t       e;
      cap  = hist[1] & ~hist[0] & ch_mask & {8{enable}};
      pop  = (exp_q.size() != 0) && out_ready;
      drop = (cap != 0) && (exp_q.size() == DEPTH) && !pop;
      if (pop) void'(exp_q.pop_front());
      if (cap != 0 && !drop) begin
        e.c = cap; e.n = count; e.o = outer_count;
        exp_q.push_back(e);
      end
      if (clear_overflow) begin
        m_ovf = drop ? 1 : 0;
        m_drp = drop ? 1 : 0;
      end else if (drop) begin
        m_ovf = 1;
        if (m_drp < 65535) m_drp++;
      end
      void'(hist.pop_front());
      hist.push_back(ch_in);
    end
  end

  // Monitor: checks status every cycle and the head whenever the DUT presents one.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 80'(out_valid), 80'(exp_q.size() != 0));
      chk("fifo_level", 80'(fifo_level), 80'(exp_q.size()));
      chk("overflow", 80'(overflow), 80'(m_ovf));
      chk("dropped", 80'(dropped), 80'(m_drp));
      if (out_valid && exp_q.size() != 0)
        chk("head", {8'h0, out_chans, out_count, out_outer},
            {8'h0, exp_q[0].c, exp_q[0].n, exp_q[0].o});
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      count = count + 1;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick(DEPTH + 4);
    out_ready = 1'b0;
    chk("drained", 80'(fifo_level), 80'(0));
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_valid", 80'(out_valid), 80'(0));
    chk("rst_level", 80'(fifo_level), 80'(0));
    chk("rst_head", {8'h0, out_chans, out_count, out_outer}, 80'(0));
    chk("rst_ovf", {63'd0, overflow, dropped}, 80'(0));
    rst_n = 1'b1;
    ch_mask = 8'hFF;
    enable = 1'b1;
    tick(4);

    // Single edge: count 100 sampled at the raising edge, timestamp 3 edges later
    count = 32'd100;
    outer_count = 32'hFFFF_FFFE;
    tick(1);
    ch_in = 8'h08;
    tick(2);
    chk("lat_early", 80'(out_valid), 80'(0));
    tick(1);
    chk("lat_valid", 80'(out_valid), 80'(1));
    chk("single", {8'h0, out_chans, out_count, out_outer}, {16'h08, 32'd103, 32'hFFFF_FFFE});
    ch_in = 8'h00;
    tick(5);
    chk("no_fall", 80'(fifo_level), 80'(1));
    drain();

    // Simultaneous edges with a masked channel
    ch_mask = 8'h7F;
    ch_in = 8'hA1;
    tick(4);
    chk("simul_lvl", 80'(fifo_level), 80'(1));
    chk("simul_chans", 80'(out_chans), 80'(8'h21));
    ch_in = 8'h00;
    drain();

    // Enable gating: a level already high when enabled does not capture
    ch_mask = 8'hFF;
    enable = 1'b0;
    ch_in = 8'h04;
    tick(5);
    enable = 1'b1;
    tick(5);
    chk("gate_none", 80'(fifo_level), 80'(0));
    ch_in = 8'h00;
    tick(1);
    ch_in = 8'h04;
    tick(4);
    chk("gate_lvl", 80'(fifo_level), 80'(1));
    chk("gate_chans", 80'(out_chans), 80'(8'h04));
    ch_in = 8'h00;
    drain();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      ch_in          = 8'($urandom);
      ch_mask        = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      enable         = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 2) == 0);
      clear_overflow = ($urandom_range(0, 31) == 0);
      outer_count    = $urandom;
      tick(1);
    end
    ch_in = 8'h00; ch_mask = 8'hFF; enable = 1'b1; clear_overflow = 1'b0;
    outer_count = 32'd7;
    drain();
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;

    // Overflow: 18 edges into a 16-deep queue with no consumer
    for (int i = 0; i < 18; i++) begin
      ch_in = 8'h40; tick(1);
      ch_in = 8'h00; tick(1);
    end
    tick(4);
    chk("ovf_level", 80'(fifo_level), 80'(16));
    chk("ovf_flag", 80'(overflow), 80'(1));
    chk("ovf_dropped", 80'(dropped), 80'(2));

    // Full with a pop in the write cycle
    outer_count = 32'hFFFF_FF00;
    ch_in = 8'h10;
    tick(2);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("fullpop_lvl", 80'(fifo_level), 80'(16));
    chk("fullpop_ovf", {63'd0, overflow, dropped}, {63'd0, 1'b1, 16'd2});
    ch_in = 8'h00;
    drain();

    // Reset mid-stream with entries queued and a toggling consumer
    for (int i = 0; i < 5; i++) begin
      ch_in = 8'h02; tick(1);
      ch_in = 8'h00; tick(1);
    end
    tick(3);
    for (int i = 0; i < 3; i++) begin
      out_ready = ($urandom_range(0, 1) == 1);
      tick(1);
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 80'(out_valid), 80'(0));
    chk("mid_rst_level", 80'(fifo_level), 80'(0));
    chk("mid_rst_ovf", 80'(overflow), 80'(0));
    tick(1);
    rst_n = 1'b1;
    out_ready = 1'b0;
    tick(3);
    count = 32'd500;
    outer_count = 32'hFFFF_FFF9;
    tick(1);
    ch_in = 8'h02;
    tick(3);
    chk("post_rst_lvl", 80'(fifo_level), 80'(1));
    chk("post_rst", {8'h0, out_chans, out_count, out_outer}, {16'h02, 32'd503, 32'hFFFF_FFF9});
    ch_in = 8'h00;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
